// File: rtl/epp_pkg.sv
// epp_pkg: shared FSM encodings, widths and helpers for epp_reg_bank (optional feature macro EPP_REG_BANK_AUTOINC_EN)
package epp_pkg;
    localparam int EPP_ADDR_W = 8;
    localparam int EPP_DATA_W = 8;
    localparam logic [EPP_DATA_W-1:0] EPP_UNMAPPED_RD = 8'h00;
    typedef enum logic [1:0] {
        EPP_REG_IDLE = 2'h0,
        EPP_REG_ACK  = 2'h1,
        EPP_REG_DONE = 2'h2
    } epp_reg_state_e;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/epp_reg_bank_if.sv
// epp_reg_bank_if: REGS_* request/acknowledge bus between the EPP slave (master) and the register bank (slave)
interface epp_reg_bank_if;
    import epp_pkg::*;
    logic                  REGS_WRITE_REQ_IN;
    logic                  REGS_READ_REQ_IN;
    logic                  REGS_ADDR_SEL_IN;
    logic                  REGS_DATA_SEL_IN;
    logic [EPP_DATA_W-1:0] REGS_WRITE_DATA_IN;
    logic                  REGS_WRITE_ACK_OUT;
    logic                  REGS_READ_ACK_OUT;
    logic [EPP_DATA_W-1:0] REGS_READ_DATA_OUT;
    modport master (
        output REGS_WRITE_REQ_IN, REGS_READ_REQ_IN, REGS_ADDR_SEL_IN, REGS_DATA_SEL_IN, REGS_WRITE_DATA_IN,
        input  REGS_WRITE_ACK_OUT, REGS_READ_ACK_OUT, REGS_READ_DATA_OUT
    );
    modport slave (
        input  REGS_WRITE_REQ_IN, REGS_READ_REQ_IN, REGS_ADDR_SEL_IN, REGS_DATA_SEL_IN, REGS_WRITE_DATA_IN,
        output REGS_WRITE_ACK_OUT, REGS_READ_ACK_OUT, REGS_READ_DATA_OUT
    );
endinterface

// File: rtl/epp_reg_decode.sv
// epp_reg_decode: combinational split of the EPP address into R/W hit, RO hit and per-bank indices
module epp_reg_decode
    import epp_pkg::*;
#(
    parameter int NUM_RW_REGS = 8,
    parameter int NUM_RO_REGS = 8,
    parameter int RW_IW       = 3,
    parameter int RO_IW       = 3
) (
    input  logic [EPP_ADDR_W-1:0] addr,
    output logic                  rw_hit,
    output logic                  ro_hit,
    output logic [RW_IW-1:0]      rw_idx,
    output logic [RO_IW-1:0]      ro_idx
);
    // R/W bank sits at the bottom of the map, RO bank directly above it
    always_comb begin
        rw_hit = int'(addr) < NUM_RW_REGS;
        ro_hit = !rw_hit && int'(addr) < NUM_RW_REGS + NUM_RO_REGS;
        rw_idx = RW_IW'(addr);
        ro_idx = RO_IW'(addr - EPP_ADDR_W'(NUM_RW_REGS));
    end
endmodule

// File: rtl/epp_reg_bank.sv
// epp_reg_bank: EPP address register plus R/W control and RO status bytes behind the REGS_* handshake; EPP_REG_BANK_AUTOINC_EN enables address auto-increment
module epp_reg_bank
    import epp_pkg::*;
#(
    parameter int                    NUM_RW_REGS  = 8,
    parameter int                    NUM_RO_REGS  = 8,
    parameter logic [EPP_DATA_W-1:0] RW_RESET_VAL = 8'h00
) (
    input  logic                     CLK,
    input  logic                     RST_SYNC_N,
    input  logic                     EN,
    epp_reg_bank_if.slave            regs,
    output logic [8*NUM_RW_REGS-1:0] RW_REGS_OUT,
    input  logic [8*NUM_RO_REGS-1:0] RO_REGS_IN,
    output logic [NUM_RW_REGS-1:0]   WR_STB_OUT
);
    localparam int RW_IW = idx_w(NUM_RW_REGS);
    localparam int RO_IW = idx_w(NUM_RO_REGS);
`ifdef EPP_REG_BANK_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    epp_reg_state_e                          state_q, state_d;
    logic [EPP_ADDR_W-1:0]                   addr_q, addr_d;
    logic [EPP_DATA_W-1:0]                   rdata_q, rdata_d, data_rd;
    logic [NUM_RW_REGS-1:0][EPP_DATA_W-1:0]  rw_q, rw_d;
    logic [NUM_RO_REGS-1:0][EPP_DATA_W-1:0]  ro;
    logic [NUM_RW_REGS-1:0]                  stb_q, stb_d;
    logic                                    wack_q, wack_d, rack_q, rack_d;
    logic                                    rw_hit, ro_hit, any_req, is_rd, data_tgt;
    logic [RW_IW-1:0]                        rw_idx;
    logic [RO_IW-1:0]                        ro_idx;

    epp_reg_decode #(
        .NUM_RW_REGS(NUM_RW_REGS),
        .NUM_RO_REGS(NUM_RO_REGS),
        .RW_IW      (RW_IW),
        .RO_IW      (RO_IW)
    ) u_decode (
        .addr  (addr_q),
        .rw_hit(rw_hit),
        .ro_hit(ro_hit),
        .rw_idx(rw_idx),
        .ro_idx(ro_idx)
    );

    assign ro       = RO_REGS_IN;
    assign any_req  = regs.REGS_WRITE_REQ_IN | regs.REGS_READ_REQ_IN;
    assign is_rd    = regs.REGS_READ_REQ_IN;
    assign data_tgt = regs.REGS_DATA_SEL_IN & ~regs.REGS_ADDR_SEL_IN;
    assign data_rd  = rw_hit ? rw_q[rw_idx] : ro_hit ? ro[ro_idx] : EPP_UNMAPPED_RD;

    // Handshake next-state: accept in IDLE, drop ack in ACK, wait for requests to clear in DONE
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        rdata_d = rdata_q;
        stb_d   = stb_q;
        wack_d  = wack_q;
        rack_d  = rack_q;
        if (EN) begin
            stb_d  = '0;
            wack_d = 1'b0;
            rack_d = 1'b0;
            case (state_q)
                EPP_REG_IDLE: if (any_req) begin
                    state_d = EPP_REG_ACK;
                    rack_d  = is_rd;
                    wack_d  = !is_rd;
                    if (AUTOINC && data_tgt) addr_d = addr_q + 8'd1;
                    if (is_rd) rdata_d = regs.REGS_ADDR_SEL_IN ? addr_q : data_tgt ? data_rd : EPP_UNMAPPED_RD;
                    else if (regs.REGS_ADDR_SEL_IN) addr_d = regs.REGS_WRITE_DATA_IN;
                    else if (data_tgt && rw_hit) begin
                        rw_d[rw_idx]  = regs.REGS_WRITE_DATA_IN;
                        stb_d[rw_idx] = 1'b1;
                    end
                end
                EPP_REG_ACK: state_d = EPP_REG_DONE;
                default: if (!any_req) state_d = EPP_REG_IDLE;
            endcase
        end
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_SYNC_N) begin
            state_q <= EPP_REG_IDLE;
            addr_q  <= '0;
            rw_q    <= {NUM_RW_REGS{RW_RESET_VAL}};
            rdata_q <= '0;
            stb_q   <= '0;
            wack_q  <= 1'b0;
            rack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            rdata_q <= rdata_d;
            stb_q   <= stb_d;
            wack_q  <= wack_d;
            rack_q  <= rack_d;
        end
    end

    assign regs.REGS_WRITE_ACK_OUT = wack_q;
    assign regs.REGS_READ_ACK_OUT  = rack_q;
    assign regs.REGS_READ_DATA_OUT = rdata_q;
    assign RW_REGS_OUT             = rw_q;
    assign WR_STB_OUT              = stb_q;
endmodule

// File: tb/tb_epp_reg_bank.sv
// tb_epp_reg_bank: table-driven directed bench for epp_reg_bank plus reset, enable and auto-increment sequences
module tb_epp_reg_bank;
    localparam int NRW = 8;
    localparam int NRO = 8;
`ifdef EPP_REG_BANK_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    logic                 CLK = 1'b0;
    logic                 RST_SYNC_N = 1'b0;
    logic                 EN = 1'b1;
    logic [8*NRW-1:0]     rw_out;
    logic [8*NRO-1:0]     ro_in;
    logic [NRW-1:0]       stb;
    int                   n_cmp = 0;
    int                   n_bad = 0;

    epp_reg_bank_if bus();

    epp_reg_bank #(
        .NUM_RW_REGS (NRW),
        .NUM_RO_REGS (NRO),
        .RW_RESET_VAL(8'h00)
    ) dut (
        .CLK        (CLK),
        .RST_SYNC_N (RST_SYNC_N),
        .EN         (EN),
        .regs       (bus),
        .RW_REGS_OUT(rw_out),
        .RO_REGS_IN (ro_in),
        .WR_STB_OUT (stb)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit         wr, rd, asel, dsel;
        logic [7:0] wd;
        int         hold;
        int         ew, er;
        bit         crd;
        logic [7:0] erd;
        logic [7:0] estb;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_bus(input bit wr, input bit rd, input bit asel, input bit dsel, input logic [7:0] wd);
        bus.REGS_WRITE_REQ_IN  = wr;
        bus.REGS_READ_REQ_IN   = rd;
        bus.REGS_ADDR_SEL_IN   = asel;
        bus.REGS_DATA_SEL_IN   = dsel;
        bus.REGS_WRITE_DATA_IN = wd;
    endtask

    // One upstream transaction: raise request, drop it 'hold' cycles after the ack, watch 20 cycles total
    task automatic access(input bit wr, input bit rd, input bit asel, input bit dsel, input logic [7:0] wd,
                          input int hold, output int wacks, output int racks, output int lat,
                          output int stb_cyc, output logic [7:0] rdat, output logic [7:0] stb_or);
        int drop;
        drop = -1; wacks = 0; racks = 0; lat = -1; stb_cyc = 0; rdat = 'x; stb_or = '0;
        @(negedge CLK);
        set_bus(wr, rd, asel, dsel, wd);
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (stb != '0) begin
                stb_cyc++;
                stb_or |= stb;
            end
            if (bus.REGS_WRITE_ACK_OUT || bus.REGS_READ_ACK_OUT) begin
                if (lat < 0) begin
                    lat  = c;
                    drop = c + hold;
                end
                wacks += int'(bus.REGS_WRITE_ACK_OUT);
                racks += int'(bus.REGS_READ_ACK_OUT);
                if (bus.REGS_READ_ACK_OUT) rdat = bus.REGS_READ_DATA_OUT;
            end
            if (c == drop) set_bus(0, 0, 0, 0, 8'h00);
        end
        set_bus(0, 0, 0, 0, 8'h00);
    endtask

    initial begin
        vec_t       v[26];
        int         wa, ra, lat, sc, got;
        logic [7:0] rd, so;
        for (int k = 0; k < NRO; k++) ro_in[8*k +: 8] = (k == 2) ? 8'h5C : 8'(8'h50 + k);
        set_bus(0, 0, 0, 0, 8'h00);
        //        wr rd as ds  wd   hold ew er crd erd  estb
        v[0]  = '{0, 1, 1, 0, 8'h00, 1, 0, 1, 1, 8'h00, 8'h00};
        v[1]  = '{1, 0, 1, 0, 8'h03, 1, 1, 0, 0, 8'h00, 8'h00};
        v[2]  = '{1, 0, 0, 1, 8'hA5, 1, 1, 0, 0, 8'h00, 8'h08};
        v[3]  = '{0, 1, 1, 0, 8'h00, 1, 0, 1, 1, AI ? 8'h04 : 8'h03, 8'h00};
        v[4]  = '{1, 0, 1, 0, 8'h03, 1, 1, 0, 0, 8'h00, 8'h00};
        v[5]  = '{0, 1, 0, 1, 8'h00, 1, 0, 1, 1, 8'hA5, 8'h00};
        v[6]  = '{1, 0, 1, 0, 8'h0A, 1, 1, 0, 0, 8'h00, 8'h00};
        v[7]  = '{0, 1, 0, 1, 8'h00, 1, 0, 1, 1, 8'h5C, 8'h00};
        v[8]  = '{1, 0, 1, 0, 8'h40, 1, 1, 0, 0, 8'h00, 8'h00};
        v[9]  = '{0, 1, 0, 1, 8'h00, 1, 0, 1, 1, 8'h00, 8'h00};
        v[10] = '{1, 0, 1, 0, 8'h40, 1, 1, 0, 0, 8'h00, 8'h00};
        v[11] = '{1, 0, 0, 1, 8'h77, 1, 1, 0, 0, 8'h00, 8'h00};
        v[12] = '{1, 0, 1, 0, 8'h00, 1, 1, 0, 0, 8'h00, 8'h00};
        v[13] = '{1, 0, 0, 1, 8'h3C, 6, 1, 0, 0, 8'h00, 8'h01};
        v[14] = '{1, 0, 1, 0, 8'h00, 1, 1, 0, 0, 8'h00, 8'h00};
        v[15] = '{1, 1, 0, 1, 8'h99, 1, 0, 1, 1, 8'h3C, 8'h00};
        v[16] = '{0, 1, 0, 0, 8'h00, 1, 0, 1, 1, 8'h00, 8'h00};
        v[17] = '{1, 0, 0, 0, 8'hEE, 1, 1, 0, 0, 8'h00, 8'h00};
        v[18] = '{1, 0, 1, 0, 8'h0F, 1, 1, 0, 0, 8'h00, 8'h00};
        v[19] = '{0, 1, 0, 1, 8'h00, 1, 0, 1, 1, 8'h57, 8'h00};
        v[20] = '{1, 0, 1, 0, 8'h10, 1, 1, 0, 0, 8'h00, 8'h00};
        v[21] = '{0, 1, 0, 1, 8'h00, 1, 0, 1, 1, 8'h00, 8'h00};
        v[22] = '{1, 0, 1, 0, 8'h07, 1, 1, 0, 0, 8'h00, 8'h00};
        v[23] = '{1, 0, 0, 1, 8'h11, 1, 1, 0, 0, 8'h00, 8'h80};
        v[24] = '{1, 0, 1, 1, 8'h05, 1, 1, 0, 0, 8'h00, 8'h00};
        v[25] = '{0, 1, 1, 0, 8'h00, 1, 0, 1, 1, 8'h05, 8'h00};

        repeat (3) @(negedge CLK);
        chk("reset wack", bus.REGS_WRITE_ACK_OUT, 0);
        chk("reset rack", bus.REGS_READ_ACK_OUT, 0);
        chk("reset rdata", bus.REGS_READ_DATA_OUT, 8'h00);
        chk("reset stb", stb, 0);
        chk("reset rw_regs", rw_out, 64'h0);
        RST_SYNC_N = 1'b1;

        for (int i = 0; i < 26; i++) begin
            access(v[i].wr, v[i].rd, v[i].asel, v[i].dsel, v[i].wd, v[i].hold, wa, ra, lat, sc, rd, so);
            chk($sformatf("vec%0d wacks", i), wa, v[i].ew);
            chk($sformatf("vec%0d racks", i), ra, v[i].er);
            chk($sformatf("vec%0d latency", i), lat, 0);
            chk($sformatf("vec%0d stb", i), so, v[i].estb);
            chk($sformatf("vec%0d stb_cycles", i), sc, (v[i].estb != 0) ? 1 : 0);
            if (v[i].crd) chk($sformatf("vec%0d rdata", i), rd, v[i].erd);
        end
        chk("rw_regs final", rw_out, 64'h11000000_A500003C);

        // Reset while in DONE with a read request still held
        access(1, 0, 1, 0, 8'h22, 1, wa, ra, lat, sc, rd, so);
        @(negedge CLK);
        set_bus(0, 1, 1, 0, 8'h00);
        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            @(negedge CLK);
            if (bus.REGS_READ_ACK_OUT) begin
                got = 1;
                rd  = bus.REGS_READ_DATA_OUT;
            end
        end
        chk("rst_done pre ack", got, 1);
        chk("rst_done pre data", rd, 8'h22);
        @(negedge CLK);
        RST_SYNC_N = 1'b0;
        @(negedge CLK);
        chk("rst_done rack in reset", bus.REGS_READ_ACK_OUT, 0);
        chk("rst_done rdata in reset", bus.REGS_READ_DATA_OUT, 8'h00);
        chk("rst_done rw_regs", rw_out, 64'h0);
        RST_SYNC_N = 1'b1;
        got = 0;
        for (int c = 0; c < 5 && got == 0; c++) begin
            @(negedge CLK);
            if (bus.REGS_READ_ACK_OUT) begin
                got = 1;
                rd  = bus.REGS_READ_DATA_OUT;
            end
        end
        chk("rst_done reaccept ack", got, 1);
        chk("rst_done addr cleared", rd, 8'h00);
        set_bus(0, 0, 0, 0, 8'h00);
        repeat (3) @(negedge CLK);

        // Enable low: request must wait
        EN = 1'b0;
        set_bus(1, 0, 1, 0, 8'h33);
        got = 0;
        repeat (5) begin
            @(negedge CLK);
            if (bus.REGS_WRITE_ACK_OUT || bus.REGS_READ_ACK_OUT) got++;
        end
        chk("en_low no ack", got, 0);
        EN = 1'b1;
        got = 0;
        for (int c = 0; c < 5 && got == 0; c++) begin
            @(negedge CLK);
            if (bus.REGS_WRITE_ACK_OUT) got = 1;
        end
        chk("en_high ack", got, 1);
        @(negedge CLK);
        set_bus(0, 0, 0, 0, 8'h00);
        repeat (3) @(negedge CLK);
        access(0, 1, 1, 0, 8'h00, 1, wa, ra, lat, sc, rd, so);
        chk("en addr written", rd, 8'h33);

`ifdef EPP_REG_BANK_AUTOINC_EN
        access(1, 0, 1, 0, 8'hFF, 1, wa, ra, lat, sc, rd, so);
        access(1, 0, 0, 1, 8'h12, 1, wa, ra, lat, sc, rd, so);
        chk("ai unmapped wack", wa, 1);
        chk("ai unmapped stb", so, 8'h00);
        access(1, 0, 0, 1, 8'h34, 1, wa, ra, lat, sc, rd, so);
        chk("ai wrap stb", so, 8'h01);
        chk("ai wrap reg0", rw_out[7:0], 8'h34);
        access(0, 1, 1, 0, 8'h00, 1, wa, ra, lat, sc, rd, so);
        chk("ai addr after", rd, 8'h01);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/epp_reg_bank.md
Name: epp_reg_bank

Overview:
- Register bank that sits directly downstream of the EPP slave and consumes its REGS_* request/acknowledge interface.
- Holds an 8-bit EPP address register, selected by address-strobe cycles.
- Holds NUM_RW_REGS read/write control registers driven into the FPGA core, and NUM_RO_REGS read-only status registers sampled from the core. Both are selected by data-strobe cycles.
- Gives the PC (Adept) software a flat 256-location byte map.

Parameters:
- NUM_RW_REGS, 8, count of R/W registers at addresses 0x00..NUM_RW_REGS-1 (1..128).
- NUM_RO_REGS, 8, count of RO registers at addresses NUM_RW_REGS..NUM_RW_REGS+NUM_RO_REGS-1 (1..128; the sum must be ≤256).
- RW_RESET_VAL, 8'h00, reset value of every R/W register.

Ports:
- CLK  in  1  core clock
- RST_SYNC_N  in  1  synchronous active-low reset
- EN  in  1  clock enable; when low all state holds
- REGS_WRITE_REQ_IN  in  1  write request level, held until ack
- REGS_READ_REQ_IN  in  1  read request level, held until ack
- REGS_ADDR_SEL_IN  in  1  access targets the address register
- REGS_DATA_SEL_IN  in  1  access targets the register selected by the address register
- REGS_WRITE_DATA_IN  in  8  write data, valid while the write request is high
- REGS_WRITE_ACK_OUT  out  1  single-cycle write acknowledge
- REGS_READ_ACK_OUT  out  1  single-cycle read acknowledge
- REGS_READ_DATA_OUT  out  8  read data, valid in the read-ack cycle
- RW_REGS_OUT  out  8*NUM_RW_REGS  R/W register contents; register k occupies bits [8k+7:8k]
- RO_REGS_IN  in  8*NUM_RO_REGS  status bytes, same packing
- WR_STB_OUT  out  NUM_RW_REGS  one-hot, one-cycle pulse marking the R/W register written this cycle

Behaviour:
- Reset (RST_SYNC_N=0 at a CLK edge, regardless of EN):
  - address register = 8'h00
  - all R/W registers = RW_RESET_VAL
  - FSM = IDLE
  - both acks = 0, WR_STB_OUT = 0, REGS_READ_DATA_OUT = 8'h00
- All outputs are registered. Nothing advances while EN=0.
- Handshake FSM, states IDLE, ACK, DONE:
  - IDLE: if either request is high, perform the access, set the matching ack for one cycle, go to ACK. This gives a one-cycle request-to-ack latency.
  - ACK: deassert the ack, go to DONE.
  - DONE: stay until both requests are low, then go to IDLE. This guarantees exactly one ack per request, because the upstream request drops one cycle after it samples the ack.
  - If both requests are high at once (illegal), treat the access as a read and set only the read ack.
  - If neither select is high when a request is accepted, still ack. A read returns 8'h00; a write has no effect.
- Address-select write: address register <= REGS_WRITE_DATA_IN.
- Address-select read: read data = address register.
- Data-select write:
  - addr < NUM_RW_REGS: update R/W register [addr] and pulse WR_STB_OUT[addr] in the same cycle as the ack.
  - Any other address: ignored, no strobe.
- Data-select read:
  - addr < NUM_RW_REGS: R/W register [addr].
  - addr in the RO range: RO_REGS_IN byte [addr-NUM_RW_REGS], sampled at the accept edge.
  - Any other address: 8'h00.
- RO_REGS_IN is assumed synchronous to CLK and is sampled only at the accept edge.
- If both selects are high, the address register is the target.
- Reset taken mid-handshake: the FSM returns to IDLE. A request still held high after reset is accepted as a new access.

Optional Feature:
- Macro: EPP_REG_BANK_AUTOINC_EN.
- Defined: after every acked data-select access (read or write, mapped or not), the address register increments by 1 modulo 256, so 0xFF wraps to 0x00. The increment lands in the ACK cycle. An address-select write in the same access takes priority.
- Undefined: the address register changes only on address-select writes.

Decomposition:
- Shared package epp_pkg holds:
  - FSM encodings EPP_REG_IDLE=2'h0, EPP_REG_ACK=2'h1, EPP_REG_DONE=2'h2
  - EPP_ADDR_W=8, EPP_DATA_W=8
  - EPP_UNMAPPED_RD=8'h00
- One sub-module is natural: epp_reg_decode, a combinational address decode producing rw_hit, ro_hit and the index.

Test Plan:
- Reset, then address-select read → REGS_READ_DATA_OUT=8'h00; RW_REGS_OUT equals RW_RESET_VAL replicated.
- Address write 8'h03, then data write 8'hA5 → RW_REGS_OUT[31:24]=8'hA5; WR_STB_OUT=8'b0000_1000 for exactly one cycle; exactly one write ack per request.
- RO_REGS_IN byte 2 = 8'h5C, address write 8'h0A, data read → read ack with data 8'h5C. Address 8'h40 read → 8'h00; write to 8'h40 produces no strobe and still acks.
- Request held high for 6 cycles after the ack → no second ack. Both requests high together → read ack only.
- With EPP_REG_BANK_AUTOINC_EN: address 8'hFF, then two data writes → first write ignored, address wraps to 8'h00, second write lands in RW register 0 (WR_STB_OUT bit 0 pulses).
- Drive RST_SYNC_N low while the FSM is in DONE → FSM returns to IDLE and the address register clears. With EN low, requests are not acked until EN rises.
